// File: rtl/mod_counter_pkg.sv
// Shared types and limits for the modulo counter slice.
// Pure declarations; no logic, no latency, no flow control.
package counter_pkg;

    typedef enum logic {
        MODE_WRAP = 1'b0,
        MODE_SAT  = 1'b1
    } cnt_mode_e;

    localparam int CNT_MAX_WIDTH = 32;

endpackage

// File: rtl/mod_counter_if.sv
// Control/status bundle of mod_counter; master drives controls, slave returns count state.
// No storage of its own; no backpressure.
interface mod_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             clr;
    logic             load;
    logic [WIDTH-1:0] load_val;
    logic             ovf_clr;
    logic [WIDTH-1:0] count;
    logic             tc;
    logic             ovf;

    modport master (
        output en, up, clr, load, load_val, ovf_clr,
        input  count, tc, ovf
    );

    modport slave (
        input  en, up, clr, load, load_val, ovf_clr,
        output count, tc, ovf
    );
endinterface

// File: rtl/mod_counter_prescaler.sv
// Divides enabled cycles by PRESCALE; tick is combinational from the phase register and en.
// Phase updates one edge later; no backpressure, holds while en=0.
module counter_prescaler #(
    parameter int PRESCALE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic sync_clr,
    output logic tick
);

    localparam int            PW      = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [PW-1:0] LP_LAST = PW'(PRESCALE - 1);

    logic [PW-1:0] r_pre_cnt;

    // With PRESCALE=1 the phase never leaves 0, so tick degenerates to en.
    assign tick = en && (r_pre_cnt == LP_LAST);

    always_ff @(posedge clk) begin
        if (rst || sync_clr) begin
            r_pre_cnt <= '0;
        end else if (tick) begin
            r_pre_cnt <= '0;
        end else if (en) begin
            r_pre_cnt <= r_pre_cnt + PW'(1);
        end
    end

endmodule

// File: rtl/mod_counter.sv
// Up/down modulo-MOD counter with prescaler, wrap/saturate boundary, tc pulse and sticky ovf.
// Latency: one edge from input to count/tc/ovf; no backpressure, every edge is accepted.
module mod_counter
    import counter_pkg::*;
#(
    parameter int        WIDTH    = 4,
    parameter int        MOD      = 10,
    parameter cnt_mode_e MODE     = MODE_WRAP,
    parameter int        PRESCALE = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             en,
    input  logic             up,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             ovf_clr,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             ovf
);

    if (WIDTH < 1 || WIDTH > CNT_MAX_WIDTH) begin : g_bad_width
        $fatal(1, "mod_counter: WIDTH out of range");
    end
    if (MOD < 2 || longint'(MOD) > (longint'(1) << WIDTH)) begin : g_bad_mod
        $fatal(1, "mod_counter: MOD must be in 2..2**WIDTH");
    end
    if (PRESCALE < 1) begin : g_bad_prescale
        $fatal(1, "mod_counter: PRESCALE must be >= 1");
    end

    localparam logic [WIDTH:0]   LP_MOD  = (WIDTH+1)'(MOD);
    localparam logic [WIDTH-1:0] LP_LAST = WIDTH'(MOD - 1);

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic             r_ovf;

    logic             w_tick;
    logic             w_step;
    logic             w_bnd;
    logic [WIDTH:0]   w_cnt_ext;
    logic [WIDTH:0]   w_sum;
    logic [WIDTH:0]   w_load_ext;
    logic [WIDTH-1:0] w_next;

    counter_prescaler #(
        .PRESCALE (PRESCALE)
    ) u_prescaler (
        .clk      (clk),
        .rst      (rst),
        .en       (en),
        .sync_clr (clr | load),
        .tick     (w_tick)
    );

    assign w_cnt_ext  = {1'b0, r_count};
    assign w_load_ext = {1'b0, load_val};
    assign w_sum      = up ? (w_cnt_ext + (WIDTH+1)'(1)) : (w_cnt_ext - (WIDTH+1)'(1));

    // Up hits the boundary when the sum reaches MOD; down when it borrows into the extra bit.
    assign w_bnd  = up ? (w_sum == LP_MOD) : w_sum[WIDTH];
    assign w_step = w_tick && !clr && !load;

    always_comb begin
        w_next = r_count;
        if (clr) begin
            w_next = '0;
        end else if (load) begin
            w_next = (w_load_ext >= LP_MOD) ? LP_LAST : load_val;
        end else if (w_step) begin
            if (!w_bnd) begin
                w_next = w_sum[WIDTH-1:0];
            end else if (MODE == MODE_WRAP) begin
                w_next = up ? '0 : LP_LAST;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
            r_ovf   <= 1'b0;
        end else begin
            r_count <= w_next;
            r_tc    <= w_step && w_bnd;
            // Boundary set takes precedence over a simultaneous ovf_clr.
            r_ovf   <= (w_step && w_bnd) || (r_ovf && !ovf_clr);
        end
    end

    assign count = r_count;
    assign tc    = r_tc;
    assign ovf   = r_ovf;

endmodule

// File: tb/tb_mod_counter.sv
// Bench: three counters (wrap/P1, sat/P1, wrap/P3) share stimulus and are checked against a behavioural model.
module tb_mod_counter;
    import counter_pkg::*;

    localparam int W = 4;
    localparam int M = 10;
    localparam int N = 3;
    localparam bit SAT  [N] = '{1'b0, 1'b1, 1'b0};
    localparam int PRES [N] = '{1, 1, 3};

    logic         clk = 1'b0;
    logic         rst, en, up, clr, load, ovf_clr;
    logic [W-1:0] load_val;

    logic [W-1:0] a_cnt [N];
    logic         a_tc  [N];
    logic         a_ovf [N];

    always #5 clk = ~clk;

    for (genvar gi = 0; gi < N; gi++) begin : g_dut
        mod_counter_if #(.WIDTH(W)) ifc ();

        assign ifc.en       = en;
        assign ifc.up       = up;
        assign ifc.clr      = clr;
        assign ifc.load     = load;
        assign ifc.load_val = load_val;
        assign ifc.ovf_clr  = ovf_clr;

        mod_counter #(
            .WIDTH    (W),
            .MOD      (M),
            .MODE     (SAT[gi] ? MODE_SAT : MODE_WRAP),
            .PRESCALE (PRES[gi])
        ) dut (
            .clk      (clk),
            .rst      (rst),
            .en       (ifc.en),
            .up       (ifc.up),
            .clr      (ifc.clr),
            .load     (ifc.load),
            .load_val (ifc.load_val),
            .ovf_clr  (ifc.ovf_clr),
            .count    (ifc.count),
            .tc       (ifc.tc),
            .ovf      (ifc.ovf)
        );

        assign a_cnt[gi] = ifc.count;
        assign a_tc[gi]  = ifc.tc;
        assign a_ovf[gi] = ifc.ovf;
    end

    int n_chk = 0;
    int n_err = 0;
    bit chk_en = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Behavioural model: plain integer counters following the counting rules.
    int m_cnt [N];
    int m_pre [N];
    bit m_tc  [N];
    bit m_ovf [N];

    always @(posedge clk) begin
        for (int i = 0; i < N; i++) begin
            if (rst) begin
                m_cnt[i] = 0; m_pre[i] = 0; m_tc[i] = 0; m_ovf[i] = 0;
            end else begin
                m_tc[i] = 0;
                if (ovf_clr) m_ovf[i] = 0;
                if (clr) begin
                    m_cnt[i] = 0; m_pre[i] = 0;
                end else if (load) begin
                    m_cnt[i] = (int'(load_val) > M - 1) ? M - 1 : int'(load_val);
                    m_pre[i] = 0;
                end else if (en) begin
                    m_pre[i] = m_pre[i] + 1;
                    if (m_pre[i] == PRES[i]) begin
                        m_pre[i] = 0;
                        if ((up && m_cnt[i] == M - 1) || (!up && m_cnt[i] == 0)) begin
                            m_tc[i]  = 1;
                            m_ovf[i] = 1;
                            if (!SAT[i]) m_cnt[i] = up ? 0 : M - 1;
                        end else begin
                            m_cnt[i] = up ? m_cnt[i] + 1 : m_cnt[i] - 1;
                        end
                    end
                end
            end
        end
    end

    always @(negedge clk) begin
        if (chk_en) begin
            for (int i = 0; i < N; i++) begin
                check($sformatf("model_cnt[%0d]", i), a_cnt[i], m_cnt[i]);
                check($sformatf("model_tc[%0d]",  i), a_tc[i],  m_tc[i]);
                check($sformatf("model_ovf[%0d]", i), a_ovf[i], m_ovf[i]);
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1; en = 0; clr = 0; load = 0; ovf_clr = 0; up = 1; load_val = '0;
        cyc();
        rst = 0;
    endtask

    initial begin
        int pulses;
        int exp_cnt [4];
        int exp_tc  [4];
        rst = 1; en = 0; up = 1; clr = 0; load = 0; ovf_clr = 0; load_val = '0;
        @(negedge clk);
        cyc(); cyc();
        chk_en = 1'b1;
        for (int i = 0; i < N; i++) begin
            check("reset_cnt", a_cnt[i], 0);
            check("reset_tc",  a_tc[i],  0);
            check("reset_ovf", a_ovf[i], 0);
        end

        // Wrap up from reset: 1..9,0,1,2 with one tc pulse on the 0.
        do_reset();
        en = 1; up = 1; pulses = 0;
        for (int k = 1; k <= 12; k++) begin
            cyc();
            if (a_tc[0] === 1'b1) pulses++;
            if (k == 10) begin
                check("wrap_zero_cnt", a_cnt[0], 0);
                check("wrap_zero_tc",  a_tc[0],  1);
            end
            if (k == 5) check("wrap_cnt5", a_cnt[0], 5);
        end
        check("wrap_end_cnt",   a_cnt[0], 2);
        check("wrap_tc_pulses", pulses,   1);
        check("wrap_ovf",       a_ovf[0], 1);
        check("model_pin_wrap", m_cnt[0], 2);
        check("model_pin_sat",  m_cnt[1], 9);

        // Saturating down from a loaded 2.
        do_reset();
        load = 1; load_val = 4'd2;
        cyc();
        load = 0; up = 0; en = 1;
        exp_cnt = '{1, 0, 0, 0};
        exp_tc  = '{0, 0, 1, 1};
        for (int k = 0; k < 4; k++) begin
            cyc();
            check($sformatf("sat_cnt%0d", k), a_cnt[1], exp_cnt[k]);
            check($sformatf("sat_tc%0d",  k), a_tc[1],  exp_tc[k]);
        end
        check("sat_ovf", a_ovf[1], 1);

        // Prescale by 3: steps on edges 3, 6, 9, then holds with en low.
        do_reset();
        en = 1; up = 1;
        for (int k = 1; k <= 9; k++) begin
            cyc();
            check($sformatf("pre_cnt_e%0d", k), a_cnt[2], k / 3);
        end
        en = 0;
        for (int k = 0; k < 5; k++) begin
            cyc();
            check("pre_hold", a_cnt[2], 3);
        end
        check("model_pin_pre", m_cnt[2], 3);

        // clr beats load beats a boundary step; oversize load clamps.
        do_reset();
        load = 1; load_val = 4'd9;
        cyc();
        check("prio_load9", a_cnt[1], 9);
        clr = 1; load = 1; load_val = 4'd7; en = 1; up = 1;
        cyc();
        check("prio_cnt", a_cnt[1], 0);
        check("prio_tc",  a_tc[1],  0);
        check("prio_ovf", a_ovf[1], 0);
        clr = 0; load = 1; load_val = 4'd12; en = 0;
        cyc();
        check("clamp_cnt", a_cnt[1], 9);
        load = 0;

        // Boundary set wins over ovf_clr; ovf_clr alone then clears.
        en = 1; up = 1; ovf_clr = 1;
        cyc();
        check("sticky_cnt", a_cnt[1], 9);
        check("sticky_tc",  a_tc[1],  1);
        check("sticky_ovf", a_ovf[1], 1);
        en = 0;
        cyc();
        check("ovfclr_ovf", a_ovf[1], 0);
        check("ovfclr_tc",  a_tc[1],  0);
        ovf_clr = 0;

        // Reset mid-prescale at count 5.
        do_reset();
        en = 1; up = 1;
        repeat (16) cyc();
        check("mid_cnt5",  a_cnt[2], 5);
        check("mid_ovf0",  a_ovf[0], 1);
        rst = 1;
        cyc();
        rst = 0;
        check("rstmid_cnt", a_cnt[2], 0);
        check("rstmid_tc",  a_tc[2],  0);
        check("rstmid_ovf", a_ovf[0], 0);
        cyc(); cyc();
        check("rstmid_wait", a_cnt[2], 0);
        cyc();
        check("rstmid_first", a_cnt[2], 1);

        // Randomised traffic, checked every cycle by the model.
        for (int k = 0; k < 400; k++) begin
            rst      = ($urandom_range(0, 59) == 0);
            clr      = ($urandom_range(0, 19) == 0);
            load     = ($urandom_range(0, 14) == 0);
            load_val = W'($urandom_range(0, 15));
            en       = ($urandom_range(0, 3) != 0);
            up       = ($urandom_range(0, 2) != 0) ^ (k >= 200);
            ovf_clr  = ($urandom_range(0, 7) == 0);
            cyc();
        end
        rst = 0; clr = 0; load = 0; en = 0; ovf_clr = 0;
        cyc();
        chk_en = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
